axi_ready_slice: RTL and testbench
==================================

# axi_ready_slice

Two-entry skid buffer for a single AXI channel (AW, W, AR, R or B). It cuts the backward `ready` path with a register, complementing `axi_single_slice`, which buffers the forward `valid`/`data` path. Insert it between a master-side and a slave-side channel wherever the `ready` timing path is critical. It sustains full throughput: one beat per cycle.

## Interface
Parameters:
- `DATA_WIDTH`, default -1: width of the flattened channel payload. Must be overridden with a value ≥ 1; elaboration fails otherwise.

Ports:
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  reset. Synchronous and active-high.
- `testmode_i`  in  1  present so the block can be swapped with `axi_single_slice`; no functional effect.
- `valid_i`  in  1  upstream beat valid.
- `ready_o`  out  1  upstream ready. Driven from a register except during reset (see Timing).
- `data_i`  in  `DATA_WIDTH`  upstream payload.
- `ready_i`  in  1  downstream ready.
- `valid_o`  out  1  downstream beat valid.
- `data_o`  out  `DATA_WIDTH`  downstream payload. Driven from the main register.
- `count_o`  out  2  occupancy, 0..2.

## Operation
- Storage is two registers:
  - main register: drives `data_o`, with flag `main_full`.
  - skid register, with flag `skid_full`.
- Output equations:
  - `ready_o = !skid_full & !rst_i`
  - `valid_o = main_full & !rst_i`
- Handshakes:
  - push = `valid_i & ready_o`
  - pop = `valid_o & ready_i`
- State machine with states EMPTY, ONE, TWO:
  - EMPTY, push → ONE; main ← `data_i`.
  - EMPTY, no push → EMPTY. A pop is impossible because `valid_o` = 0.
  - ONE, push & pop → ONE; main ← `data_i`.
  - ONE, push & !pop → TWO; skid ← `data_i`.
  - ONE, !push & pop → EMPTY.
  - ONE, idle → ONE, hold.
  - TWO, pop → ONE; main ← skid. A push is impossible because `ready_o` = 0.
  - TWO, !pop → TWO, hold.
- Order is strict FIFO. No beat is dropped or duplicated.
- `count_o` = 0, 1 or 2 for EMPTY, ONE or TWO.
- `data_o` holds stable while `valid_o` = 1 and `ready_i` = 0, as AXI requires.
- The block never deasserts `valid_o` without a pop.

## Timing
- Latency: a beat pushed in cycle N is presented on `valid_o`/`data_o` in cycle N+1.
- Throughput: one beat per cycle whenever `ready_i` stays high.
- No combinational path from `ready_i` to `ready_o`, or from `valid_i`/`data_i` to `valid_o`/`data_o`.
- `ready_o` falls in the cycle after the first stalled push in state ONE. At most one extra beat is then absorbed into the skid register.
- `ready_o` returns to 1 in the cycle after a pop from TWO.
- Reset (`rst_i` = 1 at a rising edge) sets:
  - state = EMPTY,
  - `main_full` = `skid_full` = 0,
  - both data registers = '0,
  - `count_o` = 0.
- While `rst_i` = 1, `ready_o` = 0 and `valid_o` = 0, so no handshake can complete.
- In the first cycle after `rst_i` falls: `ready_o` = 1, `valid_o` = 0, `data_o` = 0.
- Reset asserted mid-operation (ONE or TWO): buffered beats are discarded. This is legal only when the whole channel resets together.
- Simultaneous push and pop in ONE replaces main with no bubble. Occupancy stays 1.

## Structure
- Shared package `axi_slice_pkg` holds `typedef enum logic [1:0] {EMPTY, ONE, TWO} slice_state_e`, which `axi_single_slice` wrappers may also reuse.
- Single flat module, no sub-module. The two registers are too small to justify one.
- Embedded assertions, compiled out for synthesis:
  - `valid_o` and `data_o` stable while stalled;
  - `count_o` never exceeds 2;
  - no push while `ready_o` = 0.

## Test plan
- **Reset:** hold `rst_i` = 1 for 3 cycles with `valid_i` = 1 and `data_i` = 8'hAA → `ready_o` = 0 and `valid_o` = 0 throughout. After release: `ready_o` = 1, `valid_o` = 0, `count_o` = 0, `data_o` = 0.
- **Streaming:** `DATA_WIDTH` = 8, `ready_i` = 1, push 0x01..0x10 back-to-back → outputs 0x01..0x10 one per cycle, each 1 cycle after its push. `ready_o` never drops.
- **Fill and stall:** `ready_i` = 0, push 0x11, 0x22, then offer 0x33 → `count_o` reaches 2 and `ready_o` = 0. 0x33 is not accepted. `data_o` holds 0x11 stable.
- **Drain from TWO:** from the previous state, raise `ready_i` → output 0x11, then 0x22. `ready_o` returns to 1 one cycle after the first pop. 0x33 is then accepted and emerges third.
- **Random traffic:** random `valid_i`/`ready_i` at 50% for 10k cycles, checked against a scoreboard → order preserved, no loss or duplication, all assertions clean.
- **Reset in TWO:** reach `count_o` = 2, then pulse `rst_i` for 1 cycle → next cycle `count_o` = 0, `valid_o` = 0, `ready_o` = 1. The pre-reset beats never appear on the output.

Source files
------------

// File: rtl/axi_slice_pkg.sv
// rtl/axi_slice_pkg.sv - shared state type for the AXI channel slices
package axi_slice_pkg;

  // Occupancy states shared by the ready slice and the single-slice wrappers.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } slice_state_e;

  // Number of beats held in each state.
  function automatic logic [1:0] state_count(slice_state_e s);
    case (s)
      EMPTY:   return 2'd0;
      ONE:     return 2'd1;
      TWO:     return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/axi_ready_slice.sv
// rtl/axi_ready_slice.sv - two-entry skid buffer registering the backward ready path
module axi_ready_slice
  import axi_slice_pkg::*;
#(
  parameter int DATA_WIDTH = -1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  testmode_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [1:0]            count_o
);

  // The payload width has no sensible default; refuse to build without one.
  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("axi_ready_slice: DATA_WIDTH must be overridden with a value >= 1");
  end

  // testmode_i only exists for port compatibility with axi_single_slice.
  logic unused_testmode;
  assign unused_testmode = testmode_i;

  slice_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  main_full;
  logic                  skid_full;
  logic                  push;
  logic                  pop;

  // Occupancy flags follow directly from the registered state.
  assign main_full = (state_q != EMPTY);
  assign skid_full = (state_q == TWO);

  // Both handshake outputs come from registers, gated only by reset.
  assign ready_o = !skid_full && !rst_i;
  assign valid_o = main_full && !rst_i;
  assign data_o  = main_q;
  assign count_o = state_count(state_q);

  assign push = valid_i && ready_o;
  assign pop  = valid_o && ready_i;

  // Next-state and register-load selection; main always holds the oldest beat.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          main_d  = data_i;
        end
      end
      ONE: begin
        if (push && pop) begin
          main_d = data_i;
        end else if (push) begin
          state_d = TWO;
          skid_d  = data_i;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // State and data registers; reset discards any buffered beats.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifndef SYNTHESIS
  // A stalled beat must stay presented unchanged until it is taken.
  property p_stall_stable;
    @(posedge clk_i) disable iff (rst_i)
      (valid_o && !ready_i) |=> (valid_o && $stable(data_o));
  endproperty
  a_stall_stable: assert property (p_stall_stable);

  // Occupancy never exceeds the two registers.
  property p_count_max;
    @(posedge clk_i) disable iff (rst_i) (count_o <= 2'd2);
  endproperty
  a_count_max: assert property (p_count_max);

  // When full, upstream must see ready low so no push can land.
  property p_no_push_full;
    @(posedge clk_i) disable iff (rst_i) (state_q == TWO) |-> !push;
  endproperty
  a_no_push_full: assert property (p_no_push_full);
`endif

endmodule

// File: tb/tb_axi_ready_slice.sv
// tb/tb_axi_ready_slice.sv - directed and scoreboard checks for axi_ready_slice
module tb_axi_ready_slice;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       testmode_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] data_i;
  logic       ready_i;
  logic       valid_o;
  logic [7:0] data_o;
  logic [1:0] count_o;

  int n_tests = 0;
  int n_fail  = 0;

  axi_ready_slice #(.DATA_WIDTH(8)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .testmode_i (testmode_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .data_i     (data_i),
    .ready_i    (ready_i),
    .valid_o    (valid_o),
    .data_o     (data_o),
    .count_o    (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive inputs just after a rising edge, then wait to the falling edge to sample.
  task automatic tick(input logic r, input logic v, input logic [7:0] d, input logic rdy);
    @(posedge clk_i);
    #1;
    rst_i   = r;
    valid_i = v;
    data_i  = d;
    ready_i = rdy;
    @(negedge clk_i);
  endtask

  logic [7:0] sb[$];
  logic [7:0] v8;

  initial begin
    rst_i      = 1'b1;
    testmode_i = 1'b0;
    valid_i    = 1'b1;
    data_i     = 8'hAA;
    ready_i    = 1'b0;

    // Reset held three cycles with a beat offered.
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, 8'hAA, 1'b0);
      check("rst_ready", ready_o, 0);
      check("rst_valid", valid_o, 0);
    end
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    check("post_rst_ready", ready_o, 1);
    check("post_rst_valid", valid_o, 0);
    check("post_rst_count", count_o, 0);
    check("post_rst_data", data_o, 0);

    // Streaming 0x01..0x10 with ready_i high: one cycle latency, no stalls.
    for (int i = 1; i <= 16; i++) begin
      tick(1'b0, 1'b1, 8'(i), 1'b1);
      check("stream_ready", ready_o, 1);
      if (i == 1) begin
        check("stream_first_valid", valid_o, 0);
      end else begin
        check("stream_valid", valid_o, 1);
        check("stream_data", data_o, 32'(i - 1));
      end
    end
    tick(1'b0, 1'b0, 8'h00, 1'b1);
    check("stream_last_valid", valid_o, 1);
    check("stream_last_data", data_o, 32'h10);
    tick(1'b0, 1'b0, 8'h00, 1'b1);
    check("stream_drained", valid_o, 0);
    check("stream_count0", count_o, 0);

    // Fill and stall.
    tick(1'b0, 1'b1, 8'h11, 1'b0);
    check("fill_count0", count_o, 0);
    tick(1'b0, 1'b1, 8'h22, 1'b0);
    check("fill_count1", count_o, 1);
    check("fill_data1", data_o, 32'h11);
    check("fill_ready1", ready_o, 1);
    tick(1'b0, 1'b1, 8'h33, 1'b0);
    check("fill_count2", count_o, 2);
    check("fill_ready2", ready_o, 0);
    check("fill_data2", data_o, 32'h11);
    tick(1'b0, 1'b1, 8'h33, 1'b0);
    check("stall_count", count_o, 2);
    check("stall_valid", valid_o, 1);
    check("stall_data", data_o, 32'h11);

    // Drain from TWO; 0x33 is accepted once ready_o returns.
    tick(1'b0, 1'b1, 8'h33, 1'b1);
    check("drain_data11", data_o, 32'h11);
    check("drain_ready_lo", ready_o, 0);
    tick(1'b0, 1'b1, 8'h33, 1'b1);
    check("drain_data22", data_o, 32'h22);
    check("drain_ready_hi", ready_o, 1);
    check("drain_count1", count_o, 1);
    tick(1'b0, 1'b0, 8'h00, 1'b1);
    check("drain_data33", data_o, 32'h33);
    check("drain_valid33", valid_o, 1);
    tick(1'b0, 1'b0, 8'h00, 1'b1);
    check("drain_empty", valid_o, 0);

    // Random traffic against a FIFO scoreboard.
    sb.delete();
    for (int i = 0; i < 10000; i++) begin
      v8 = 8'($urandom);
      tick(1'b0, 1'($urandom_range(0, 1)), v8, 1'($urandom_range(0, 1)));
      check("rnd_count", count_o, 32'(sb.size()));
      check("rnd_ready", ready_o, (sb.size() < 2) ? 1 : 0);
      check("rnd_valid", valid_o, (sb.size() > 0) ? 1 : 0);
      if (sb.size() > 0) begin
        check("rnd_data", data_o, 32'(sb[0]));
        if (ready_i) void'(sb.pop_front());
      end
      if (valid_i && (sb.size() < 2 || (sb.size() == 2 && 1'b0))) begin
        if (ready_o) sb.push_back(data_i);
      end
    end
    // Drain whatever remains.
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 8'h00, 1'b1);
      if (sb.size() > 0) begin
        check("rnd_tail_data", data_o, 32'(sb[0]));
        void'(sb.pop_front());
      end
    end
    check("rnd_tail_empty", valid_o, 0);

    // Reset in TWO discards both beats.
    tick(1'b0, 1'b1, 8'hA1, 1'b0);
    tick(1'b0, 1'b1, 8'hA2, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    check("rst2_count2", count_o, 2);
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    check("rst2_ready_in", ready_o, 0);
    check("rst2_valid_in", valid_o, 0);
    tick(1'b0, 1'b0, 8'h00, 1'b1);
    check("rst2_count", count_o, 0);
    check("rst2_valid", valid_o, 0);
    check("rst2_ready", ready_o, 1);
    check("rst2_data", data_o, 0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 8'h00, 1'b1);
      check("rst2_no_ghost", valid_o, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
